sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Two-client front end for the single-port SDRAM controller in the NES design.
- Client 0 is the CPU (PRG/WRAM side); client 1 is the PPU (CHR side). Each client has a req/ack handshake.
- The block serialises their byte accesses onto the controller's CE/WE/Addr/WrData/RdData interface, which has no ready signal.
- It pulses CE once per access, times the controller's fixed 5-cycle sequence, captures RdData and returns it to the granted client.

Parameters:
- ADDR_W, 23, byte address width (bank/row/column packed, as the controller expects).
- DATA_W, 8, client data width.
- CTRL_LAT, 5, clocks from the cycle CE is high to the first cycle mem_rdata is valid; CTRL_LAT >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- p0_req  in  1  client 0 request, level; held with its signals until p0_ack.
- p0_we  in  1  client 0 write (1) / read (0).
- p0_addr  in  ADDR_W  client 0 byte address.
- p0_wdata  in  DATA_W  client 0 write byte.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_W  read result; valid with p0_ack, held until the next client 0 read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as client 0, for client 1.
- mem_ce  out  1  to controller CE.
- mem_we  out  1  to controller WE.
- mem_addr  out  ADDR_W  to controller Addr.
- mem_wdata  out  DATA_W  to controller WrData.
- mem_rdata  in  DATA_W  from controller RdData.
- gnt  out  2  one-hot current owner; 00 when idle (debug/visibility).

Behaviour:
- Reset values (all synchronous): state IDLE; mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0; p0_ack=p1_ack=0; p0_rdata=p1_rdata=0; gnt=00; last_grant=1, so client 0 wins the first tie.
- The controller shares the same reset. Reset mid-transaction aborts it with no ack, and the next transaction starts from IDLE.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Sample p0_req and p1_req.
  - Only one asserted: grant it.
  - Both asserted: grant the client not equal to last_grant (round-robin).
  - On grant, register the winner's we/addr/wdata onto mem_we/mem_addr/mem_wdata, set gnt, update last_grant, go to ISSUE.
  - Neither asserted: stay in IDLE, mem_ce=0.
- ISSUE (cycle t): mem_ce=1 for exactly this one cycle. Load the wait counter with CTRL_LAT-2. Go to WAIT.
- WAIT (cycles t+1..t+CTRL_LAT-1):
  - mem_ce=0.
  - Decrement the counter; go to DONE when it reaches 0.
  - mem_addr/we/wdata stay stable throughout.
- DONE (cycle t+CTRL_LAT):
  - mem_rdata is valid this cycle.
  - If the granted op is a read, copy mem_rdata into that client's rdata register.
  - Pulse that client's ack for 1 cycle; the other client's ack stays 0.
  - Clear gnt; go to IDLE.
- Latency and throughput:
  - Request to ack, uncontended, with req high when IDLE is entered: CTRL_LAT+2 clocks (IDLE sample, ISSUE, 4×WAIT, DONE at default).
  - One access per CTRL_LAT+2 clocks maximum. At most one mem_ce in any window of CTRL_LAT clocks, which guarantees the controller is back in its idle state before the next CE.
- Write ops:
  - Ack timing is identical to reads.
  - rdata is not modified.
- Handshake rules:
  - Clients must hold req, we, addr and wdata until ack.
  - Only the IDLE-cycle sample matters; later changes are ignored because mem_* are registered.
  - The cycle after ack is IDLE. If req is still high there, it is a new request. Back-to-back requests from one client alternate with the other client whenever the other is pending.
- Clients request byte addresses; byte-lane selection is the controller's job. The arbiter passes addresses unmodified.

Test Plan:
- Single read: preload model word at 0x000100 = 0x44332211; p0 read 0x000102 → mem_ce one cycle with mem_addr=0x000102, mem_we=0; p0_ack 7 clocks after req; p0_rdata=0x33; p1_ack stays 0.
- Single write: p1 writes 0xA5 to 0x400003 → mem_we=1, mem_wdata=0xA5 during ISSUE; p1_ack pulses; a subsequent p1 read of 0x400003 returns 0xA5; p1_rdata unchanged by the write itself.
- Simultaneous requests from reset: p0 and p1 assert in the same cycle → p0 granted first; p1 is issued at the next IDLE, exactly 7 clocks after p0's CE. Both rdata values are correct.
- Fairness: p0_req held high continuously with p1_req also high → grants alternate 0,1,0,1 for 8 accesses; no client is served twice in a row.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT → no ack; all outputs return to reset values next cycle. A request held through reset completes normally afterwards.
- CE spacing: random traffic on both ports for 1000 cycles → never two mem_ce within 5 clocks; every req gets exactly one ack; the scoreboard matches the memory model.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Two-client front end for the single-port SDRAM controller. Client 0 is the
// CPU (PRG/WRAM), client 1 is the PPU (CHR). Each byte access is serialised
// onto the controller's CE/WE/Addr/WrData/RdData interface. CE is pulsed once
// per access, and the controller's fixed latency is timed with a down-counter.
// Ack and read data are registered outputs. They appear together in the cycle
// after DONE. The FSM is back in IDLE in that cycle, and it ignores the client
// whose ack is currently showing. A client that is still holding req therefore
// makes a new request only in the cycle after it sees ack.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 8,
    parameter int CTRL_LAT = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        gnt
);

    localparam int                CNT_W    = $clog2(CTRL_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CTRL_LAT - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_grant;
    logic [1:0]        r_gnt;
    logic              r_mem_ce;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [1:0]        w_req_raw;
    logic [1:0]        w_req;
    logic [1:0]        w_ack;
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_pick1;

    assign w_req_raw = {p1_req, p0_req};

    // Client 1 wins if it is the only requester, or if both request and client 0 was served last.
    assign w_pick1 = w_req[1] & (~w_req[0] | ~r_last_grant);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_client
            logic              r_ack;
            logic [DATA_W-1:0] r_rdata;
            logic              w_done_mine;

            assign w_done_mine = (r_state == ST_DONE) && r_gnt[gi];

            // One-cycle completion pulse; read data is captured only for this client's reads.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                end else begin
                    r_ack <= w_done_mine;
                    if (w_done_mine && !r_mem_we) begin
                        r_rdata <= mem_rdata;
                    end
                end
            end

            assign w_ack[gi]   = r_ack;
            assign w_rdata[gi] = r_rdata;
            // The request still visible during the ack cycle is the one just served.
            assign w_req[gi]   = w_req_raw[gi] & ~r_ack;
        end
    endgenerate

    // Access sequencer: arbitrate in IDLE, one CE cycle, fixed wait, then complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_gnt        <= 2'b00;
            r_mem_ce     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mem_ce <= 1'b0;
                    if (|w_req) begin
                        r_state      <= ST_ISSUE;
                        r_mem_ce     <= 1'b1;
                        r_last_grant <= w_pick1;
                        r_gnt        <= w_pick1 ? 2'b10 : 2'b01;
                        r_mem_we     <= w_pick1 ? p1_we    : p0_we;
                        r_mem_addr   <= w_pick1 ? p1_addr  : p0_addr;
                        r_mem_wdata  <= w_pick1 ? p1_wdata : p0_wdata;
                    end
                end
                ST_ISSUE: begin
                    r_mem_ce <= 1'b0;
                    r_cnt    <= CNT_LOAD;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_gnt   <= 2'b00;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_ce <= 1'b0;
                    r_gnt    <= 2'b00;
                end
            endcase
        end
    end

    assign mem_ce    = r_mem_ce;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign gnt       = r_gnt;
    assign p0_ack    = w_ack[0];
    assign p1_ack    = w_ack[1];
    assign p0_rdata  = w_rdata[0];
    assign p1_rdata  = w_rdata[1];

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
// Directed and random checks of the two-client SDRAM arbiter against a small
// model of the fixed-latency controller and a per-address expected-data shadow.
module tb_sdram_port_arbiter;
    localparam int ADDR_W   = 23;
    localparam int DATA_W   = 8;
    localparam int CTRL_LAT = 5;
    localparam int ACC_CYC  = CTRL_LAT + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              p0_req = 1'b0, p0_we = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;
    logic              p1_req = 1'b0, p1_we = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;
    logic              mem_ce, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = 8'hEE;
    logic [1:0]        gnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTRL_LAT(CTRL_LAT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .gnt(gnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- controller model: data valid CTRL_LAT clocks after the CE cycle
    logic [7:0]        mem_model [int];
    logic [7:0]        shadow [int];
    int                lat_cnt = 0;
    logic [ADDR_W-1:0] lat_addr = '0;

    function automatic logic [7:0] mem_default(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= 8'hEE;
        if (reset) begin
            lat_cnt = 0;
        end else if (mem_ce) begin
            lat_cnt  = CTRL_LAT - 1;
            lat_addr = mem_addr;
            if (mem_we) mem_model[int'(mem_addr)] = mem_wdata;
        end else if (lat_cnt > 0) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
                mem_rdata <= mem_model.exists(int'(lat_addr)) ? mem_model[int'(lat_addr)]
                                                              : mem_default(lat_addr);
            end
        end
    end

    // ---------------- bus monitor
    int                ce_cnt = 0, last_ce_cyc = 0, prev_ce_cyc = 0;
    bit                ce_seen = 1'b0;
    logic [ADDR_W-1:0] last_ce_addr = '0;
    logic              last_ce_we = 1'b0;
    logic [7:0]        last_ce_wdata = '0;
    logic [1:0]        last_ce_gnt = '0;
    logic [1:0]        gnt_q [$];
    int                ack_cnt0 = 0, ack_cnt1 = 0;

    always @(negedge clk) begin
        if (reset) begin
            ce_seen = 1'b0;
        end else begin
            if (mem_ce) begin
                if (ce_seen)
                    check("ce_spacing", ((cyc - last_ce_cyc) >= CTRL_LAT) ? 32'd1 : 32'd0, 32'd1);
                check("ce_gnt_onehot", 32'($countones(gnt)), 32'd1);
                prev_ce_cyc   = last_ce_cyc;
                last_ce_cyc   = cyc;
                last_ce_addr  = mem_addr;
                last_ce_we    = mem_we;
                last_ce_wdata = mem_wdata;
                last_ce_gnt   = gnt;
                gnt_q.push_back(gnt);
                ce_cnt++;
                ce_seen = 1'b1;
            end
            if (p0_ack || p1_ack) check("ack_exclusive", 32'(p0_ack & p1_ack), 32'd0);
            if (p0_ack) ack_cnt0++;
            if (p1_ack) ack_cnt1++;
        end
    end

    // ---------------- stimulus helpers
    task automatic drive_req(input int c, input logic req, input logic we,
                             input logic [ADDR_W-1:0] a, input logic [7:0] d);
        if (c == 0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic wait_ack(input int c, input int budget, output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            seen = (c == 0) ? p0_ack : p1_ack;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"},  32'({mem_ce, mem_we, gnt, p0_ack, p1_ack}), 32'd0);
        check({tag, "_addr"},  32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_rdata"}, 32'({p0_rdata, p1_rdata}), 32'd0);
    endtask

    // One uncontended access: latency, bus fields, rdata and the silent other port.
    task automatic do_access(input string tag, input int c, input logic we,
                             input logic [ADDR_W-1:0] a, input logic [7:0] d,
                             input logic [7:0] exp_rd);
        bit         seen;
        int         n, ce0, oth0;
        logic [7:0] rd_before, rd_now;
        ce0       = ce_cnt;
        oth0      = (c == 0) ? ack_cnt1 : ack_cnt0;
        rd_before = (c == 0) ? p0_rdata : p1_rdata;
        drive_req(c, 1'b1, we, a, d);
        wait_ack(c, 4 * ACC_CYC, seen, n);
        drive_req(c, 1'b0, 1'b0, '0, '0);
        rd_now = (c == 0) ? p0_rdata : p1_rdata;
        check({tag, "_ack"},       32'(seen), 32'd1);
        check({tag, "_lat"},       32'(n), 32'(ACC_CYC));
        check({tag, "_rdata"},     32'(rd_now), 32'(we ? rd_before : exp_rd));
        check({tag, "_other_ack"}, 32'((c == 0) ? p1_ack : p0_ack), 32'd0);
        check({tag, "_ce_cnt"},    32'(ce_cnt - ce0), 32'd1);
        check({tag, "_ce_addr"},   32'(last_ce_addr), 32'(a));
        check({tag, "_ce_we"},     32'(last_ce_we), 32'(we));
        if (we) check({tag, "_ce_wdata"}, 32'(last_ce_wdata), 32'(d));
        check({tag, "_ce_gnt"},    32'(last_ce_gnt), (c == 0) ? 32'd1 : 32'd2);
        @(negedge clk);
        #1;
        check({tag, "_ack_pulse"}, 32'({p0_ack, p1_ack, gnt}), 32'd0);
        check({tag, "_other_cnt"}, 32'(((c == 0) ? ack_cnt1 : ack_cnt0) - oth0), 32'd0);
        $display("[TB] %s c%0d we=%0d addr=0x%06h wdata=0x%02h rdata=0x%02h lat=%0d",
                 tag, c, we, a, d, rd_now, n);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // Random traffic from one client in its own address window.
    task automatic client_rand(input int c, input int t_end, output int issued);
        bit                seen;
        int                n;
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [7:0]        d, exp_rd, got;
        issued = 0;
        while (cyc < t_end) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            we = 1'($urandom_range(0, 1));
            a  = ((c == 0) ? 23'h000200 : 23'h400100) + ADDR_W'($urandom_range(0, 15));
            d  = 8'($urandom);
            exp_rd = shadow.exists(int'(a)) ? shadow[int'(a)] : mem_default(a);
            drive_req(c, 1'b1, we, a, d);
            issued++;
            wait_ack(c, 3 * ACC_CYC, seen, n);
            drive_req(c, 1'b0, 1'b0, '0, '0);
            got = (c == 0) ? p0_rdata : p1_rdata;
            check($sformatf("rand_c%0d_ack", c), 32'(seen), 32'd1);
            if (we) shadow[int'(a)] = d;
            else    check($sformatf("rand_c%0d_rdata", c), 32'(got), 32'(exp_rd));
            $display("[TB] rand c%0d we=%0d addr=0x%06h wdata=0x%02h rdata=0x%02h wait=%0d",
                     c, we, a, d, got, n);
        end
    endtask

    // ---------------- main sequence
    initial begin
        bit seen;
        int n, acks, q0, a0, a1, iss0, iss1, t_end;

        mem_model[32'h100] = 8'h11;
        mem_model[32'h101] = 8'h22;
        mem_model[32'h102] = 8'h33;
        mem_model[32'h103] = 8'h44;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        #1 reset = 1'b0;

        // single read, single write, read back
        do_access("rd_single",   0, 1'b0, 23'h000102, 8'h00, 8'h33);
        do_access("wr_single",   1, 1'b1, 23'h400003, 8'hA5, 8'h00);
        do_access("rd_after_wr", 1, 1'b0, 23'h400003, 8'h00, 8'hA5);

        // simultaneous requests straight out of reset: client 0 first
        pulse_reset();
        drive_req(0, 1'b1, 1'b0, 23'h000102, 8'h00);
        drive_req(1, 1'b1, 1'b0, 23'h400003, 8'h00);
        wait_ack(0, 4 * ACC_CYC, seen, n);
        drive_req(0, 1'b0, 1'b0, '0, '0);
        check("sim_p0_ack", 32'(seen), 32'd1);
        check("sim_p0_lat", 32'(n), 32'(ACC_CYC));
        check("sim_p0_rdata", 32'(p0_rdata), 32'h33);
        check("sim_p1_not_yet", 32'(p1_ack), 32'd0);
        wait_ack(1, 4 * ACC_CYC, seen, n);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        check("sim_p1_ack", 32'(seen), 32'd1);
        check("sim_p1_wait", 32'(n), 32'(ACC_CYC));
        check("sim_p1_rdata", 32'(p1_rdata), 32'hA5);
        #1;
        check("sim_ce_gap", 32'(last_ce_cyc - prev_ce_cyc), 32'(ACC_CYC));
        check("sim_p1_gnt", 32'(last_ce_gnt), 32'd2);
        $display("[TB] simultaneous p0=0x%02h p1=0x%02h", p0_rdata, p1_rdata);

        // fairness: both held, 8 accesses alternate 0,1,0,1...
        @(negedge clk);
        q0   = gnt_q.size();
        acks = 0;
        n    = 0;
        drive_req(0, 1'b1, 1'b0, 23'h000101, 8'h00);
        drive_req(1, 1'b1, 1'b0, 23'h400003, 8'h00);
        while (acks < 8 && n < 8 * ACC_CYC + 20) begin
            @(negedge clk);
            n++;
            if (p0_ack) begin
                acks++;
                check("fair_p0_rdata", 32'(p0_rdata), 32'h22);
                $display("[TB] fair ack c0 rdata=0x%02h", p0_rdata);
            end
            if (p1_ack) begin
                acks++;
                check("fair_p1_rdata", 32'(p1_rdata), 32'hA5);
                $display("[TB] fair ack c1 rdata=0x%02h", p1_rdata);
            end
            if (acks >= 8) begin
                drive_req(0, 1'b0, 1'b0, '0, '0);
                drive_req(1, 1'b0, 1'b0, '0, '0);
            end
        end
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        check("fair_acks", 32'(acks), 32'd8);
        repeat (2 * ACC_CYC) @(negedge clk);
        #1;
        check("fair_ce_cnt", 32'(gnt_q.size() - q0), 32'd8);
        if (gnt_q.size() >= q0 + 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("fair_gnt%0d", i), 32'(gnt_q[q0 + i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // reset during WAIT: aborted with no ack, held request then completes
        a0 = ack_cnt0;
        drive_req(0, 1'b1, 1'b0, 23'h000101, 8'h00);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_state("rstw");
        #1 reset = 1'b0;
        wait_ack(0, 4 * ACC_CYC, seen, n);
        drive_req(0, 1'b0, 1'b0, '0, '0);
        check("rstw_ack", 32'(seen), 32'd1);
        check("rstw_lat", 32'(n), 32'(ACC_CYC));
        check("rstw_rdata", 32'(p0_rdata), 32'h22);
        #1;
        check("rstw_ack_cnt", 32'(ack_cnt0 - a0), 32'd1);
        $display("[TB] reset-in-wait retry rdata=0x%02h lat=%0d", p0_rdata, n);

        // random traffic on both ports
        @(negedge clk);
        a0    = ack_cnt0;
        a1    = ack_cnt1;
        t_end = cyc + 1000;
        fork
            client_rand(0, t_end, iss0);
            client_rand(1, t_end, iss1);
        join
        repeat (3) @(negedge clk);
        #1;
        check("rand_acks0", 32'(ack_cnt0 - a0), 32'(iss0));
        check("rand_acks1", 32'(ack_cnt1 - a1), 32'(iss1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
